// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, sequencer
// states and small decode helpers used by both the controller and lane formatter.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   f3_nbytes = 3'd1;
            2'b01:   f3_nbytes = 3'd2;
            2'b10:   f3_nbytes = 3'd4;
            default: f3_nbytes = 3'd0;
        endcase
    endfunction

    function automatic logic f3_is_unsigned(input logic [2:0] f3);
        f3_is_unsigned = f3[2];
    endfunction

    // Stores have no unsigned variants, so bu/hu are only legal for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   addr_misaligned = off[0];
            2'b10:   addr_misaligned = (off != 2'b00);
            default: addr_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_fmt.sv
// Combinational byte-lane steering: extracts and extends load data, and merges
// store bytes into an existing RAM word, for either RAM lane layout.
module lsu_lane_fmt
    import lsu_pkg::*;
#(
    parameter bit BIG_LANES = 1'b1
) (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_value,
    output logic [31:0] o_st_word
);

    logic [7:0] w_ab [4];
    logic [1:0] w_rel [4];
    logic       w_en [4];
    logic [7:0] w_b0;
    logic [7:0] w_b1;
    logic       w_sgn_b;
    logic       w_sgn_h;
    logic [2:0] w_nb;

    function automatic logic [1:0] lane_of(input logic [1:0] off);
        lane_of = BIG_LANES ? (2'd3 - off) : off;
    endfunction

    // Reorder the RAM word into architectural byte-offset order.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_ab[k] = i_rdata[{lane_of(2'(k)), 3'b000} +: 8];
        end
    end

    // Load path: pick the addressed byte(s), lower address is the LSB.
    always_comb begin
        w_b0    = w_ab[i_off];
        w_b1    = w_ab[i_off + 2'd1];
        w_sgn_b = ~f3_is_unsigned(i_funct3) & w_b0[7];
        w_sgn_h = ~f3_is_unsigned(i_funct3) & w_b1[7];
        case (i_funct3)
            F3_B, F3_BU: o_ld_value = {{24{w_sgn_b}}, w_b0};
            F3_H, F3_HU: o_ld_value = {{16{w_sgn_h}}, w_b1, w_b0};
            F3_W:        o_ld_value = {w_ab[3], w_ab[2], w_ab[1], w_ab[0]};
            default:     o_ld_value = 32'd0;
        endcase
    end

    // Store path: offsets covered by the access take store bytes, others keep old data.
    always_comb begin
        w_nb      = f3_nbytes(i_funct3);
        o_st_word = i_rdata;
        for (int k = 0; k < 4; k++) begin
            w_rel[k] = 2'(k) - i_off;
            w_en[k]  = (2'(k) >= i_off) && ({1'b0, w_rel[k]} < w_nb);
            o_st_word[{lane_of(2'(k)), 3'b000} +: 8] =
                w_en[k] ? i_wdata[{w_rel[k], 3'b000} +: 8] : w_ab[k];
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: accepts one RV32I access, checks legality, and drives
// the synchronous word RAM (read-modify-write for sub-word stores).
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int WADDR_W   = 30,
    parameter bit BIG_LANES = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_rdata,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               mem_wen,
    input  logic [31:0]        mem_rdata
);

    lsu_state_t         r_state;
    lsu_state_t         w_next;
    logic               r_we;
    logic [2:0]         r_f3;
    logic [1:0]         r_off;
    logic [31:0]        r_wdata;
    logic [WADDR_W-1:0] r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_mem_wen;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [31:0]        r_rsp_rdata;

    logic               w_idle;
    logic               w_accept;
    logic               w_req_err;
    logic               w_req_sw;
    logic [1:0]         w_fmt_off;
    logic [2:0]         w_fmt_f3;
    logic [31:0]        w_fmt_wdata;
    logic [31:0]        w_ld_value;
    logic [31:0]        w_st_word;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = req_valid & w_idle;
    assign w_req_err = ~f3_legal(req_we, req_funct3) | addr_misaligned(req_funct3, req_addr[1:0]);
    assign w_req_sw  = req_we & (req_funct3 == F3_W);

    // The formatter sees the live request in IDLE (full-word store) and latched fields later.
    always_comb begin
        if (w_idle) begin
            w_fmt_off   = req_addr[1:0];
            w_fmt_f3    = req_funct3;
            w_fmt_wdata = req_wdata;
        end else begin
            w_fmt_off   = r_off;
            w_fmt_f3    = r_f3;
            w_fmt_wdata = r_wdata;
        end
    end

    lsu_lane_fmt #(
        .BIG_LANES (BIG_LANES)
    ) u_lane_fmt (
        .i_rdata    (mem_rdata),
        .i_off      (w_fmt_off),
        .i_funct3   (w_fmt_f3),
        .i_wdata    (w_fmt_wdata),
        .o_ld_value (w_ld_value),
        .o_st_word  (w_st_word)
    );

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!req_valid) begin
                    w_next = ST_IDLE;
                end else if (w_req_err) begin
                    w_next = ST_RESP;
                end else if (w_req_sw) begin
                    w_next = ST_WRITE;
                end else begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE:   w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE:   w_next = ST_RESP;
            ST_RESP:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch; mem_addr stays put from acceptance through the write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_f3       <= 3'd0;
            r_off      <= 2'd0;
            r_wdata    <= 32'd0;
            r_mem_addr <= '0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_f3       <= req_funct3;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_mem_addr <= req_addr[WADDR_W+1:2];
        end
    end

    // Write word: full-word stores are formatted at acceptance, sub-word ones merged in CAPTURE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_wdata <= 32'd0;
        end else if (w_accept && w_req_sw && !w_req_err) begin
            r_mem_wdata <= w_st_word;
        end else if (r_state == ST_CAPTURE && r_we) begin
            r_mem_wdata <= w_st_word;
        end
    end

    // Port strobes are registered from the next state so they track the state exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_wen   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_mem_wen   <= (w_next == ST_WRITE);
            r_rsp_valid <= (w_next == ST_RESP);
            r_req_ready <= (w_next == ST_IDLE);
        end
    end

    // Response payload updates only when entering RESP and holds otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else if (w_next == ST_RESP) begin
            r_rsp_err   <= w_idle;
            r_rsp_rdata <= (r_state == ST_CAPTURE && !r_we) ? w_ld_value : 32'd0;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wen   = r_mem_wen;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the execute stage and the word-wide synchronous data RAM. It accepts one RV32I load or store per handshake and checks alignment. Sub-word stores are done as a read-modify-write. Loads return sign- or zero-extended data with the correct byte lanes. It owns all RAM port timing, so the execute stage sees a simple valid/ready request and a one-cycle response pulse.

Parameters:
WADDR_W, 30, width of the RAM word address; mem_addr = req_addr[WADDR_W+1:2].
BIG_LANES, 1, RAM lane layout. 1: byte offset 0 is in bits [31:24] and offset 3 in [7:0]. 0: byte offset 0 is in [7:0].

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned, architectural order
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  valid with rsp_valid; misaligned address or illegal funct3
rsp_rdata  out  32  load result, extended; 0 for stores and errors
mem_addr  out  WADDR_W  RAM word address
mem_wdata  out  32  RAM write word, in RAM lane layout
mem_wen  out  1  RAM write enable
mem_rdata  in  32  RAM read word; valid one cycle after mem_addr is presented with mem_wen=0

Behaviour:
- Reset (async, reset_n=0): state=IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0. Reset at any point aborts the access in progress. mem_wen drops immediately and no partial write occurs.
- Handshake: the request is accepted on a rising edge with req_valid & req_ready. All request fields are latched then. There is no back-pressure on the response. One transaction is outstanding at most.
- Legality checks, done in IDLE at acceptance:
  - h/hu require addr[0]=0; w requires addr[1:0]=00.
  - Legal loads: funct3 in {000, 001, 010, 100, 101}. Legal stores: funct3 in {000, 001, 010}.
  - Anything else is illegal: go to RESP with rsp_err=1 and make no RAM access.
- States: IDLE, ISSUE, CAPTURE, WRITE, RESP.
  - IDLE: req_ready=1. On accept:
    - error -> RESP
    - sw -> WRITE
    - otherwise (load, sb, sh) -> ISSUE
  - ISSUE: drive mem_addr with mem_wen=0 -> CAPTURE.
  - CAPTURE: mem_rdata is valid.
    - Load: register the extracted and extended value -> RESP.
    - sb/sh: register the merged word (store bytes replace only the addressed lanes; other lanes keep mem_rdata) -> WRITE.
  - WRITE: mem_wen=1 for exactly one cycle with the registered mem_wdata -> RESP.
  - RESP: rsp_valid=1 for one cycle -> IDLE.
- mem_addr is held stable from ISSUE through WRITE.
- Latency, with accept at edge N: error rsp at N+1; sw rsp at N+2; load rsp at N+3; sb/sh rsp at N+4. Back-to-back requests are accepted on the cycle after the RESP cycle.
- Lane rules:
  - Byte offset o=addr[1:0]. Halfword offset h=addr[1].
  - Extraction selects the addressed lane(s) per BIG_LANES.
  - Multi-byte values are little-endian architecturally: the lower byte address is the LSB.
  - b/h sign-extend from bit 7/15. bu/hu zero-extend.
- rsp_rdata and rsp_err hold their values until the next RESP. A new request may be presented while rsp_valid=1 but is not accepted until IDLE.

Decomposition:
- lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum
  - size/sign field helpers
- Sub-module lsu_lane_fmt: purely combinational, parameterised by BIG_LANES.
  - Load extract/extend: rdata, o, funct3 -> value.
  - Store merge: old word, wdata, o, funct3 -> new word.
- The FSM, latching and RAM port drive stay in lsu_mem_ctrl.

Test Plan:
- BIG_LANES=1, RAM word 0x11223344 at 0x100; lb 0x103 -> rsp_rdata 0x00000044. lb 0x100 with RAM 0x80223344 -> 0xFFFFFF80. lbu 0x100 -> 0x00000080. Each at N+3.
- sh 0x102 data 0x0000BEEF onto RAM 0x11223344 -> one mem_wen pulse at N+3 with mem_wdata 0x1122EFBE. rsp_valid at N+4 with rsp_err=0.
- sw 0x200 data 0xDEADBEEF -> mem_wen at N+1, word 0xEFBEADDE, mem_addr 0x80. A following lw 0x200 returns 0xDEADBEEF.
- lw 0x102, sh 0x101, funct3 011 -> rsp_err=1 at N+1, mem_wen never asserts, rsp_rdata=0.
- Deassert reset_n during WRITE of an sb -> mem_wen=0 immediately, RAM unchanged. After release: req_ready=1 and rsp_valid=0.
- req_valid held high with 3 loads -> each accepted only in IDLE. Exactly 3 rsp_valid pulses, in order, each with correct data.
